// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the player motion controller.
//   motion_state_t : vertical/animation state of the player.
//   SPR_RISE/FALL  : sprite indices shown while airborne.
//   is_grounded()  : true for the states in which the player stands on the ground.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WALK = 3'd1,
    RISE = 3'd2,
    FALL = 3'd3,
    LAND = 3'd4
  } motion_state_t;

  localparam logic [2:0] SPR_RISE = 3'd5;
  localparam logic [2:0] SPR_FALL = 3'd6;

  function automatic logic is_grounded(input motion_state_t s);
    logic g;
    case (s)
      IDLE, WALK, LAND: g = 1'b1;
      default:          g = 1'b0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/jump_physics.sv
// jump_physics: vertical integrator of the player (position, velocity,
// gravity, fall-speed limit, jump cut and ground clamp).
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   new_frame       : state advances only when high
//   launch          : start a jump this frame (ground launch or air jump)
//   airborne        : current state is RISE or FALL
//   rising          : current state is RISE (jump cut allowed)
//   jump_released   : jump key is high this frame
//   vpos            : registered vertical position
//   touchdown       : this frame's step reaches the ground
//   vel_next        : velocity that will be stored this frame
module jump_physics #(
  parameter int VPOS_W   = 9,
  parameter int VEL_W    = 8,
  parameter int GROUND   = 320,
  parameter int JUMP_V   = 14,
  parameter int CUT_V    = 4,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_frame,
  input  logic                    launch,
  input  logic                    airborne,
  input  logic                    rising,
  input  logic                    jump_released,
  output logic [VPOS_W-1:0]       vpos,
  output logic                    touchdown,
  output logic signed [VEL_W-1:0] vel_next
);

  localparam int PW = VPOS_W + 1;
  localparam logic signed [VEL_W-1:0] LAUNCH_VEL = VEL_W'(-JUMP_V);
  localparam logic signed [VEL_W-1:0] CUT_VEL    = VEL_W'(-CUT_V);
  localparam logic signed [VEL_W:0]   MAX_VEL    = (VEL_W + 1)'(MAX_FALL);
  localparam logic signed [VEL_W:0]   GRAV       = (VEL_W + 1)'(GRAVITY);
  localparam logic signed [PW-1:0]    GROUND_POS = PW'(GROUND);

  logic signed [VEL_W-1:0] velocity_r;
  logic [VPOS_W-1:0]       pos_next_s;
  logic signed [PW-1:0]    sum_pos_s;
  logic signed [VEL_W-1:0] cut_vel_s;
  logic signed [VEL_W:0]   fall_vel_s;

  // Next position/velocity for this frame.
  always_comb begin
    // Position step uses the velocity held at the start of the frame;
    // the jump cut only shapes the velocity carried into the next frame.
    sum_pos_s  = $signed({1'b0, vpos}) + PW'(velocity_r);
    touchdown  = airborne && (sum_pos_s >= GROUND_POS);
    if (rising && jump_released && (velocity_r < CUT_VEL)) begin
      cut_vel_s = CUT_VEL;
    end else begin
      cut_vel_s = velocity_r;
    end
    // One extra bit so velocity + gravity cannot wrap before saturation.
    fall_vel_s = (VEL_W + 1)'(cut_vel_s) + GRAV;
    pos_next_s = vpos;
    vel_next   = velocity_r;
    if (launch) begin
      pos_next_s = sum_pos_s[VPOS_W-1:0];
      vel_next   = LAUNCH_VEL;
    end else if (touchdown) begin
      pos_next_s = GROUND_POS[VPOS_W-1:0];
      vel_next   = {VEL_W{1'b0}};
    end else if (airborne) begin
      pos_next_s = sum_pos_s[VPOS_W-1:0];
      vel_next   = (fall_vel_s > MAX_VEL) ? MAX_VEL[VEL_W-1:0] : fall_vel_s[VEL_W-1:0];
    end else begin
      pos_next_s = vpos;
      vel_next   = velocity_r;
    end
  end

  // Vertical state registers, advanced once per frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      vpos       <= GROUND_POS[VPOS_W-1:0];
      velocity_r <= {VEL_W{1'b0}};
    end else if (new_frame) begin
      vpos       <= pos_next_s;
      velocity_r <= vel_next;
    end else begin
      vpos       <= vpos;
      velocity_r <= velocity_r;
    end
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: per-frame player motion controller. Converts active-low
// buttons into player position, background scroll offset and sprite choice.
// Optional feature macro: PLAYER_DOUBLE_JUMP_EN (one extra jump per airborne
// period; without it, airborne jump presses are ignored).
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   new_frame                          : one-cycle pulse per video frame
//   key_right_n, key_left_n, key_jump_n: active-low buttons
//   frame_count                        : 8-bit frame counter
//   player_hpos, player_vpos           : player position
//   background_pos                     : background scroll offset (wraps mod BG_WIDTH)
//   player_sprite_count                : sprite frame index
//   player_sprite_reverse              : 1 = facing left
//   motion_state                       : current motion_state_t
module player_motion_ctrl
  import game_pkg::*;
#(
  parameter int HPOS_W     = 10,
  parameter int VPOS_W     = 9,
  parameter int VEL_W      = 8,
  parameter int START_POS  = 168,
  parameter int MIN_POS    = 128,
  parameter int MAX_POS    = 448,
  parameter int GROUND     = 320,
  parameter int WALK_SPEED = 2,
  parameter int JUMP_V     = 14,
  parameter int CUT_V      = 4,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL   = 12,
  parameter int BG_START   = 350,
  parameter int BG_WIDTH   = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_frame,
  input  logic              key_right_n,
  input  logic              key_left_n,
  input  logic              key_jump_n,
  output logic [7:0]        frame_count,
  output logic [HPOS_W-1:0] player_hpos,
  output logic [VPOS_W-1:0] player_vpos,
  output logic [HPOS_W-1:0] background_pos,
  output logic [2:0]        player_sprite_count,
  output logic              player_sprite_reverse,
  output logic [2:0]        motion_state
);

  localparam int HW = HPOS_W + 1;
  localparam logic [HW-1:0] WALK_X    = HW'(WALK_SPEED);
  localparam logic [HW-1:0] MAX_X     = HW'(MAX_POS);
  localparam logic [HW-1:0] MIN_X     = HW'(MIN_POS);
  localparam logic [HW-1:0] LEFT_LIM  = HW'(MIN_POS + WALK_SPEED);
  localparam logic [HW-1:0] BG_W      = HW'(BG_WIDTH);

  motion_state_t           state_r, state_n;
  logic [HPOS_W-1:0]       hpos_n, bg_n;
  logic                    reverse_n;
  logic [5:0]              walk_count_r, walk_count_n;
  logic [2:0]              sprite_n;
  logic                    jump_prev_r;
  logic                    right_s, left_s, one_dir_s, jump_edge_s;
  logic                    grounded_s, airborne_s;
  logic                    ground_launch_s, air_launch_s, launch_s;
  logic                    touchdown_s;
  logic signed [VEL_W-1:0] vel_next_s;
  logic [HW-1:0]           right_sum_s;

  // Background scroll helpers; operands stay below BG_WIDTH so one correction suffices.
  function automatic logic [HPOS_W-1:0] bg_add(input logic [HPOS_W-1:0] bg);
    logic [HW-1:0] sum;
    sum = {1'b0, bg} + WALK_X;
    return (sum >= BG_W) ? HPOS_W'(sum - BG_W) : sum[HPOS_W-1:0];
  endfunction

  function automatic logic [HPOS_W-1:0] bg_sub(input logic [HPOS_W-1:0] bg);
    logic [HW-1:0] ext;
    ext = {1'b0, bg};
    return (ext >= WALK_X) ? HPOS_W'(ext - WALK_X) : HPOS_W'(ext + BG_W - WALK_X);
  endfunction

  jump_physics #(
    .VPOS_W  (VPOS_W),
    .VEL_W   (VEL_W),
    .GROUND  (GROUND),
    .JUMP_V  (JUMP_V),
    .CUT_V   (CUT_V),
    .GRAVITY (GRAVITY),
    .MAX_FALL(MAX_FALL)
  ) u_jump_physics (
    .clk          (clk),
    .reset        (reset),
    .new_frame    (new_frame),
    .launch       (launch_s),
    .airborne     (airborne_s),
    .rising       (state_r == RISE),
    .jump_released(key_jump_n),
    .vpos         (player_vpos),
    .touchdown    (touchdown_s),
    .vel_next     (vel_next_s)
  );

`ifdef PLAYER_DOUBLE_JUMP_EN
  logic air_jump_r;

  // Air-jump flag: set on an air jump, cleared when the player lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      air_jump_r <= 1'b0;
    end else if (new_frame) begin
      if (state_n == LAND) begin
        air_jump_r <= 1'b0;
      end else if (air_launch_s) begin
        air_jump_r <= 1'b1;
      end else begin
        air_jump_r <= air_jump_r;
      end
    end else begin
      air_jump_r <= air_jump_r;
    end
  end

  // Air jump: touchdown in the same frame wins over the relaunch.
  always_comb begin
    air_launch_s = airborne_s && jump_edge_s && !air_jump_r && !touchdown_s;
  end
`else
  // Air jumps are not available in this build.
  always_comb begin
    air_launch_s = 1'b0;
  end
`endif

  // Key decoding, jump edge and launch decision.
  always_comb begin
    right_s         = !key_right_n;
    left_s          = !key_left_n;
    one_dir_s       = right_s ^ left_s;
    // jump_prev_r holds the raw key level of the previous frame (1 = released).
    jump_edge_s     = !key_jump_n && jump_prev_r;
    grounded_s      = is_grounded(state_r);
    airborne_s      = !grounded_s;
    ground_launch_s = grounded_s && jump_edge_s;
    launch_s        = ground_launch_s || air_launch_s;
  end

  // Motion FSM next state.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE, WALK, LAND: begin
        if (launch_s) begin
          state_n = RISE;
        end else if (one_dir_s) begin
          state_n = WALK;
        end else begin
          state_n = IDLE;
        end
      end
      RISE, FALL: begin
        if (launch_s) begin
          state_n = RISE;
        end else if (touchdown_s) begin
          state_n = LAND;
        end else if (vel_next_s[VEL_W-1]) begin
          state_n = RISE;
        end else begin
          state_n = FALL;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Horizontal movement, scroll at the boundaries, animation and sprite.
  always_comb begin
    hpos_n      = player_hpos;
    bg_n        = background_pos;
    reverse_n   = player_sprite_reverse;
    right_sum_s = {1'b0, player_hpos} + WALK_X;
    if (right_s && !left_s) begin
      reverse_n = 1'b0;
      if (right_sum_s <= MAX_X) begin
        hpos_n = right_sum_s[HPOS_W-1:0];
      end else begin
        hpos_n = MAX_X[HPOS_W-1:0];
        bg_n   = bg_sub(background_pos);
      end
    end else if (left_s && !right_s) begin
      reverse_n = 1'b1;
      if ({1'b0, player_hpos} >= LEFT_LIM) begin
        hpos_n = HPOS_W'({1'b0, player_hpos} - WALK_X);
      end else begin
        hpos_n = MIN_X[HPOS_W-1:0];
        bg_n   = bg_add(background_pos);
      end
    end else begin
      hpos_n    = player_hpos;
      bg_n      = background_pos;
      reverse_n = player_sprite_reverse;
    end
    // A started walk cycle runs on until the counter returns to zero.
    if ((state_n == WALK) || (walk_count_r != 6'd0)) begin
      walk_count_n = walk_count_r + 6'd1;
    end else begin
      walk_count_n = walk_count_r;
    end
    case (state_n)
      RISE:    sprite_n = SPR_RISE;
      FALL:    sprite_n = SPR_FALL;
      default: sprite_n = walk_count_n[5:3];
    endcase
  end

  // Frame-rate state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r               <= IDLE;
      frame_count           <= 8'd0;
      player_hpos           <= HPOS_W'(START_POS);
      background_pos        <= HPOS_W'(BG_START);
      player_sprite_reverse <= 1'b0;
      player_sprite_count   <= 3'd0;
      walk_count_r          <= 6'd0;
      jump_prev_r           <= 1'b1;
    end else if (new_frame) begin
      state_r               <= state_n;
      frame_count           <= frame_count + 8'd1;
      player_hpos           <= hpos_n;
      background_pos        <= bg_n;
      player_sprite_reverse <= reverse_n;
      player_sprite_count   <= sprite_n;
      walk_count_r          <= walk_count_n;
      jump_prev_r           <= key_jump_n;
    end else begin
      state_r               <= state_r;
      frame_count           <= frame_count;
      player_hpos           <= player_hpos;
      background_pos        <= background_pos;
      player_sprite_reverse <= player_sprite_reverse;
      player_sprite_count   <= player_sprite_count;
      walk_count_r          <= walk_count_r;
      jump_prev_r           <= jump_prev_r;
    end
  end

  assign motion_state = state_r;

endmodule

// File: doc/player_motion_ctrl.md
# player_motion_ctrl

Parametrised per-frame player motion controller for the side-scrolling game: it turns debounced, active-low button inputs into player position, background scroll offset and sprite selection. It sits between the key inputs and the sprite/background renderers. State updates once per `new_frame` pulse. Compared with the previous fixed controller, it adds configurable geometry and physics, a fall-speed limit, variable-height jumps, edge-triggered jumping and background wrap-around.

## Interface

Parameters:
- `HPOS_W`, 10: width of horizontal positions and background offset.
- `VPOS_W`, 9: width of vertical position.
- `VEL_W`, 8: width of signed vertical velocity.
- `START_POS`, 168: player hpos after reset.
- `MIN_POS`, 128: left scroll boundary.
- `MAX_POS`, 448: right scroll boundary.
- `GROUND`, 320: ground vpos.
- `WALK_SPEED`, 2: pixels per frame, horizontal.
- `JUMP_V`, 14: jump launch speed (magnitude).
- `CUT_V`, 4: velocity magnitude kept when jump is released early.
- `GRAVITY`, 1: added to velocity each airborne frame.
- `MAX_FALL`, 12: positive velocity saturation.
- `BG_START`, 350: background_pos after reset.
- `BG_WIDTH`, 1024: background wraps modulo this value.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `new_frame` in 1: one-cycle pulse per video frame.
- `key_right_n`, `key_left_n`, `key_jump_n` in 1 each: active-low buttons.
- `frame_count` out 8: frame counter.
- `player_hpos` out HPOS_W: player horizontal position.
- `player_vpos` out VPOS_W: player vertical position.
- `background_pos` out HPOS_W: background scroll offset.
- `player_sprite_count` out 3: sprite frame index.
- `player_sprite_reverse` out 1: 1 = facing left.
- `motion_state` out 3: current FSM state (package enum).

## Operation

- All registers update only on a cycle with `new_frame`=1; otherwise they hold.
- Reset values:
  - hpos=START_POS, vpos=GROUND, background_pos=BG_START.
  - frame_count=0, velocity=0, walk_count=0.
  - sprite_reverse=0, state=IDLE.
- Vertical FSM states: IDLE/WALK (grounded), RISE (velocity<0), FALL (airborne, velocity≥0), LAND (one frame on touchdown, then IDLE/WALK).
- Jump edge: a jump press is the jump key low this frame and high at the previous `new_frame` sample. A held key never re-triggers a jump.
- Jump launch, from a grounded state (IDLE, WALK or LAND) on a jump edge:
  - velocity ← −JUMP_V.
  - vpos ← vpos + old velocity (0).
  - state ← RISE.
- Airborne frames:
  - Compute next = vpos + velocity, signed, VPOS_W+1 bits.
  - If next ≥ GROUND: vpos ← GROUND, velocity ← 0, state ← LAND.
  - Otherwise: vpos ← next, velocity ← min(velocity+GRAVITY, MAX_FALL).
  - State is RISE if the new velocity is <0, else FALL.
- Variable jump height: in RISE, if the jump key is high (released) and velocity < −CUT_V, velocity ← −CUT_V before gravity is applied that frame.
- Horizontal movement:
  - Both keys pressed: no position change; facing is unchanged.
  - Right only: reverse←0. If hpos+WALK_SPEED ≤ MAX_POS, hpos advances; otherwise hpos←MAX_POS and background_pos ← (bg−WALK_SPEED) mod BG_WIDTH.
  - Left only: mirror of right, clamping at MIN_POS, with background_pos ← (bg+WALK_SPEED) mod BG_WIDTH.
  - Horizontal movement is allowed while airborne.
- Grounded state is WALK when exactly one direction key is pressed, else IDLE.
- walk_count (6-bit) increments each frame while in WALK, or while it is nonzero (finishes the cycle back to 0).
- Sprite selection: RISE→5, FALL→6, otherwise walk_count[5:3].
- frame_count increments every frame and wraps at 255→0.

## Timing

- Single-cycle latency: outputs reflect a frame update on the cycle after `new_frame`.
- Reset dominates `new_frame` in the same cycle.
- Reset mid-jump returns the block to the ground immediately (vpos=GROUND, velocity=0).
- Touchdown and a jump edge in the same frame: touchdown is taken (state LAND). The jump is accepted on the next frame only if a new edge occurs there.
- A background wrap crossing 0 or BG_WIDTH−1 is a pure modular result; no flag is produced.

## Configuration

- `PLAYER_DOUBLE_JUMP_EN`:
  - Defined: one extra jump is allowed per airborne period. A jump edge in RISE or FALL with the air-jump flag clear sets velocity←−JUMP_V, state←RISE, and sets the flag. The flag clears on LAND or reset.
  - Undefined: jump edges while airborne are ignored, and no flag register exists.

## Structure

- `game_pkg` holds:
  - the `motion_state_t` enum (IDLE, WALK, RISE, FALL, LAND);
  - sprite index constants SPR_RISE=5 and SPR_FALL=6.
- Sub-module `jump_physics` holds the vertical integrator: velocity/vpos registers, gravity, saturation, jump cut and ground clamp. The top level owns the horizontal/scroll logic, the FSM and the animation counter.

## Test plan

- Reset, then 10 frames with no keys → hpos=168, vpos=320, bg=350, frame_count=10, state IDLE, sprite 0.
- Jump edge held 40 frames with defaults:
  - vpos follows 320, 320−14, … to an apex at velocity 0, then lands at 320.
  - Sprite shows 5 then 6; LAND lasts 1 frame.
  - No second jump while the key stays held.
- Jump released on frame 2 of RISE → velocity becomes −4 and the apex is reached earlier, well below the full-jump height.
- Right held from hpos=446 → hpos 448; next frame hpos stays 448 and bg 350→348. Left held from hpos=128 with bg=1022 → bg wraps to 0.
- Long fall from a forced high vpos → velocity saturates at 12, and vpos clamps exactly to 320 on touchdown.
- With `PLAYER_DOUBLE_JUMP_EN`: a second edge in FALL relaunches at −14; a third edge is ignored. Without the macro, the second edge is ignored.
